// File: rtl/rot_align.sv
// rot_align: finds a rotated sync byte in a word stream, locks frame
// alignment and rotation, and emits de-rotated words while locked.
module rot_align #(
  parameter logic [7:0]  SYNC      = 8'hA5,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned LOCK_CNT  = 3,
  parameter int unsigned LOSS_CNT  = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       in_vld,
  output logic [7:0] out,
  output logic       out_vld,
  output logic       sof,
  output logic       locked,
  output logic [2:0] rot
);

  localparam int unsigned IDX_W = (FRAME_LEN > 2) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned CNT_W = 4;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] LOCK_TH  = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] LOSS_TH  = CNT_W'(LOSS_CNT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] hit_q, hit_d;
  logic [CNT_W-1:0] miss_q, miss_d;
  logic [2:0]       rot_q, rot_d;
  logic [7:0]       out_q, out_d;
  logic             out_vld_q, out_vld_d;
  logic             sof_q, sof_d;
  logic             locked_q, locked_d;

  logic             hunt_hit;
  logic [2:0]       hunt_k;
  logic             exp_hit;
  logic [IDX_W-1:0] idx_inc;
  logic [CNT_W-1:0] hit_inc;
  logic [CNT_W-1:0] miss_inc;
  logic             do_hunt;
  logic             emit;
  logic             emit_sof;

  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] k);
    logic [15:0] t;
    t = {x, x} << k;
    return t[15:8];
  endfunction

  function automatic logic [7:0] rotr8(input logic [7:0] x, input logic [2:0] k);
    logic [15:0] t;
    t = {x, x} >> k;
    return t[7:0];
  endfunction

  // Search all eight rotations of the sync byte; SYNC is aperiodic so at most one matches.
  always_comb begin
    hunt_hit = 1'b0;
    hunt_k   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (data == rotl8(SYNC, 3'(k))) begin
        hunt_hit = 1'b1;
        hunt_k   = 3'(k);
      end
    end
  end

  // Expected-sync match, wrapping frame index and saturating counters.
  always_comb begin
    exp_hit  = (data == rotl8(SYNC, rot_q));
    idx_inc  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    hit_inc  = (hit_q == '1) ? hit_q : hit_q + CNT_W'(1);
    miss_inc = (miss_q == '1) ? miss_q : miss_q + CNT_W'(1);
  end

  // Next-state and output decode; a VERIFY sync mismatch re-hunts on the same word.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hit_d    = hit_q;
    miss_d   = miss_q;
    rot_d    = rot_q;
    do_hunt  = 1'b0;
    emit     = 1'b0;
    emit_sof = 1'b0;

    if (in_vld) begin
      case (state_q)
        HUNT: begin
          do_hunt = 1'b1;
        end
        VERIFY: begin
          if (idx_q == '0) begin
            if (exp_hit) begin
              hit_d = hit_inc;
              idx_d = idx_inc;
              if (hit_inc >= LOCK_TH) begin
                state_d  = LOCKED;
                miss_d   = '0;
                emit     = 1'b1;
                emit_sof = 1'b1;
              end
            end else begin
              do_hunt = 1'b1;
            end
          end else begin
            idx_d = idx_inc;
          end
        end
        LOCKED: begin
          idx_d = idx_inc;
          emit  = 1'b1;
          if (idx_q == '0) begin
            if (exp_hit) begin
              miss_d   = '0;
              emit_sof = 1'b1;
            end else begin
              miss_d = miss_inc;
              if (miss_inc >= LOSS_TH) begin
                state_d = HUNT;
                hit_d   = '0;
                miss_d  = '0;
                emit    = 1'b0;
              end
            end
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase

      if (do_hunt) begin
        if (hunt_hit) begin
          rot_d  = hunt_k;
          idx_d  = IDX_W'(1);
          hit_d  = CNT_W'(1);
          miss_d = '0;
          if (CNT_W'(1) >= LOCK_TH) begin
            state_d  = LOCKED;
            emit     = 1'b1;
            emit_sof = 1'b1;
          end else begin
            state_d = VERIFY;
          end
        end else begin
          state_d = HUNT;
          hit_d   = '0;
          miss_d  = '0;
        end
      end
    end

    out_d     = emit ? rotr8(data, rot_d) : out_q;
    out_vld_d = emit;
    sof_d     = emit_sof;
    locked_d  = (state_d == LOCKED);
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      idx_q     <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
      rot_q     <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
      sof_q     <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      rot_q     <= rot_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      sof_q     <= sof_d;
      locked_q  <= locked_d;
    end
  end

  assign out     = out_q;
  assign out_vld = out_vld_q;
  assign sof     = sof_q;
  assign locked  = locked_q;
  assign rot     = rot_q;

endmodule

// File: tb/tb_rot_align.sv
// Directed bench for rot_align with default parameters (SYNC A5, 16-word frames,
// lock after 3 syncs, loss after 2 misses).
module tb_rot_align;

  logic       clk;
  logic       rst_n;
  logic [7:0] data;
  logic       in_vld;
  logic [7:0] out;
  logic       out_vld;
  logic       sof;
  logic       locked;
  logic [2:0] rot;

  int         n_vec;
  int         n_err;
  logic       exp_lock;
  logic [2:0] exp_rot;

  rot_align dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .data   (data),
    .in_vld (in_vld),
    .out    (out),
    .out_vld(out_vld),
    .sof    (sof),
    .locked (locked),
    .rot    (rot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter-side rotate-left.
  function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] k);
    logic [15:0] t;
    t = {x, x} << k;
    return t[15:8];
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    in_vld = 1'b0;
    data   = 8'h00;
    @(negedge clk);
    rst_n    = 1'b1;
    exp_lock = 1'b0;
  endtask

  // One accepted word, optionally preceded by an idle (in_vld=0) cycle.
  task automatic send_word(input logic [7:0] d, input logic ev, input logic [7:0] eo,
                           input logic es, input bit gap);
    if (gap) begin
      @(negedge clk);
      data   = 8'hFF;
      in_vld = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_out_vld", 8'(out_vld), 8'h00);
      chk("idle_locked", 8'(locked), 8'(exp_lock));
    end
    @(negedge clk);
    data   = d;
    in_vld = 1'b1;
    @(posedge clk);
    #1;
    chk("out_vld", 8'(out_vld), 8'(ev));
    chk("locked", 8'(locked), 8'(ev));
    if (ev) begin
      chk("out", out, eo);
      chk("sof", 8'(sof), 8'(es));
      chk("rot", 8'(rot), 8'(exp_rot));
    end
    exp_lock = ev;
  endtask

  // Sync word w0 then payload words 1..last_i (plaintext 8'h10+i rotated by k).
  task automatic do_frame(input logic [2:0] k, input logic [7:0] w0, input logic e0_vld,
                          input logic [7:0] e0_out, input logic e0_sof,
                          input logic pay_vld, input int last_i, input bit gap);
    logic [7:0] p;
    send_word(w0, e0_vld, e0_out, e0_sof, gap);
    for (int i = 1; i <= last_i; i++) begin
      p = 8'(32'h10 + i);
      send_word(rotl8(p, k), pay_vld, p, 1'b0, gap);
    end
  endtask

  initial begin
    logic [7:0] p;
    n_vec    = 0;
    n_err    = 0;
    exp_lock = 1'b0;
    exp_rot  = 3'd3;
    rst_n    = 1'b0;
    in_vld   = 1'b0;
    data     = 8'h00;

    // Reset values
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_out", out, 8'h00);
    chk("rst_out_vld", 8'(out_vld), 8'h00);
    chk("rst_sof", 8'(sof), 8'h00);
    chk("rst_locked", 8'(locked), 8'h00);
    chk("rst_rot", 8'(rot), 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    // Rotation 3, sync 2D: lock on third sync, payload de-rotated
    exp_rot = 3'd3;
    do_frame(3'd3, 8'h2D, 1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b0);
    do_frame(3'd3, 8'h2D, 1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b0);
    do_frame(3'd3, 8'h2D, 1'b1, 8'hA5, 1'b1, 1'b1, 15, 1'b0);

    // One corrupted sync tolerated, good sync clears, a second lone miss still tolerated
    do_frame(3'd3, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 15, 1'b0);
    do_frame(3'd3, 8'h2D, 1'b1, 8'hA5, 1'b1, 1'b1, 15, 1'b0);
    do_frame(3'd3, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 15, 1'b0);

    // Second consecutive miss drops lock; relock on rotation 5 (sync B4)
    do_frame(3'd3, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b0);
    exp_rot = 3'd5;
    do_frame(3'd5, 8'hB4, 1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b0);
    do_frame(3'd5, 8'hB4, 1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b0);
    do_frame(3'd5, 8'hB4, 1'b1, 8'hA5, 1'b1, 1'b1, 15, 1'b0);

    // Same rotation-3 stream with in_vld toggling
    do_reset();
    exp_rot = 3'd3;
    do_frame(3'd3, 8'h2D, 1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b1);
    do_frame(3'd3, 8'h2D, 1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b1);
    do_frame(3'd3, 8'h2D, 1'b1, 8'hA5, 1'b1, 1'b1, 15, 1'b1);

    // Reset pulse while locked mid-frame
    do_frame(3'd3, 8'h2D, 1'b1, 8'hA5, 1'b1, 1'b1, 4, 1'b0);
    #2;
    rst_n  = 1'b0;
    in_vld = 1'b0;
    #1;
    chk("arst_out", out, 8'h00);
    chk("arst_out_vld", 8'(out_vld), 8'h00);
    chk("arst_sof", 8'(sof), 8'h00);
    chk("arst_locked", 8'(locked), 8'h00);
    chk("arst_rot", 8'(rot), 8'h00);
    @(negedge clk);
    rst_n    = 1'b1;
    exp_lock = 1'b0;
    for (int i = 5; i <= 15; i++) begin
      p = 8'(32'h10 + i);
      send_word(rotl8(p, 3'd3), 1'b0, p, 1'b0, 1'b0);
    end
    do_frame(3'd3, 8'h2D, 1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b0);
    do_frame(3'd3, 8'h2D, 1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b0);
    do_frame(3'd3, 8'h2D, 1'b1, 8'hA5, 1'b1, 1'b1, 3, 1'b0);

    // VERIFY mismatch that is itself rotation 6 of the sync (69) recaptures at once
    do_reset();
    do_frame(3'd3, 8'h2D, 1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b0);
    send_word(8'h69, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("recapture_rot", 8'(rot), 8'h06);
    for (int i = 1; i <= 15; i++) begin
      p = 8'(32'h10 + i);
      send_word(rotl8(p, 3'd6), 1'b0, p, 1'b0, 1'b0);
    end
    exp_rot = 3'd6;
    do_frame(3'd6, 8'h69, 1'b0, 8'h00, 1'b0, 1'b0, 15, 1'b0);
    do_frame(3'd6, 8'h69, 1'b1, 8'hA5, 1'b1, 1'b1, 4, 1'b0);

    @(negedge clk);
    in_vld = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
